// File: rtl/cci_test_csr_mgr.sv
// MMIO CSR window for CCI test AFUs: decodes local CSRs, keeps event counters and
// merges local read responses with AFU responses. Optional macro: CCI_TEST_CSR_SATURATE_EN.
module cci_test_csr_mgr #(
    parameter int           NUM_TEST_CSRS        = 16,
    parameter int           NUM_VC               = 3,
    parameter int           CTR_WIDTH            = 48,
    parameter int           RSP_FIFO_DEPTH       = 4,
    parameter logic [127:0] AFU_ID               = 128'h0,
    parameter int           NEXT_DFH_BYTE_OFFSET = 0,
    parameter int           CLOCK_FREQ_MHZ       = 400
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        mmio_req_valid,
    input  logic                        mmio_req_is_rd,
    input  logic [15:0]                 mmio_req_addr,
    input  logic [8:0]                  mmio_req_tid,
    input  logic [63:0]                 mmio_req_data,
    input  logic                        afu_rsp_valid,
    input  logic [8:0]                  afu_rsp_tid,
    input  logic [63:0]                 afu_rsp_data,
    output logic                        rsp_valid,
    output logic [8:0]                  rsp_tid,
    output logic [63:0]                 rsp_data,
    input  logic                        ev_rd_valid,
    input  logic [2:0]                  ev_rd_vc,
    input  logic                        ev_rd_hit,
    input  logic                        ev_wr_valid,
    input  logic [2:0]                  ev_wr_vc,
    input  logic                        ev_wr_hit,
    input  logic [1:0]                  ev_wr_cl_num,
    input  logic                        c0_alm_full,
    input  logic                        c1_alm_full,
    output logic [NUM_TEST_CSRS-1:0]    csr_wr_en,
    output logic [63:0]                 csr_wr_data,
    input  logic [64*NUM_TEST_CSRS-1:0] csr_rd_data,
    output logic                        rsp_ovf
);
    localparam int AW = $clog2(RSP_FIFO_DEPTH);

    logic        s1_valid_q, s1_is_rd_q;
    logic [15:0] s1_addr_q;
    logic [8:0]  s1_tid_q;
    logic [63:0] s1_data_q;
    logic        s2_valid_q;
    logic [8:0]  s2_tid_q;
    logic [63:0] s2_data_q;
    logic        afu_valid_q;
    logic [8:0]  afu_tid_q;
    logic [63:0] afu_data_q;
    logic        freeze_q, ovf_q;
    logic [NUM_TEST_CSRS-1:0] wr_en_q;
    logic [63:0] wr_data_q;

    logic        ev_rd_valid_q, ev_rd_hit_q, ev_wr_valid_q, ev_wr_hit_q;
    logic [2:0]  ev_rd_vc_q, ev_wr_vc_q;
    logic [1:0]  ev_wr_cl_q;
    logic [CTR_WIDTH-1:0] rd_hit_q, rd_miss_q, wr_hit_q, wr_miss_q;
    logic [CTR_WIDTH-1:0] vc_q [NUM_VC];

    logic [72:0]   mem_q [RSP_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic [14:0] s1_idx;
    logic        s1_local, ctrl_wr, clr;
    logic [63:0] rd_data;
    logic [NUM_TEST_CSRS-1:0] wr_dec;
    logic        fifo_empty, fifo_full, pop, push_ok, drop;
    logic [2:0]  wr_inc;
    logic [2:0]  vc_inc [NUM_VC];

    assign s1_idx   = s1_addr_q[15:1];
    assign s1_local = s1_valid_q && !s1_addr_q[0] && (s1_idx < 15'(32 + NUM_TEST_CSRS));
    assign ctrl_wr  = s1_local && !s1_is_rd_q && (s1_idx == 15'd5);
    assign clr      = ctrl_wr && s1_data_q[1];

    function automatic logic [CTR_WIDTH-1:0] ctr_add(input logic [CTR_WIDTH-1:0] a,
                                                     input logic [2:0] b);
        logic [CTR_WIDTH:0] s;
        s = {1'b0, a} + (CTR_WIDTH+1)'(b);
`ifdef CCI_TEST_CSR_SATURATE_EN
        ctr_add = s[CTR_WIDTH] ? '1 : s[CTR_WIDTH-1:0];
`else
        ctr_add = s[CTR_WIDTH-1:0];
`endif
    endfunction

    always_comb begin
        rd_data = 64'h0;
        wr_dec  = '0;
        case (s1_idx)
            15'd0:  rd_data = {4'h1, 20'h0, 24'(NEXT_DFH_BYTE_OFFSET), 16'h0};
            15'd1:  rd_data = AFU_ID[63:0];
            15'd2:  rd_data = AFU_ID[127:64];
            15'd5:  rd_data = {62'h0, freeze_q, 1'b0};
            15'd8:  rd_data = 64'(CLOCK_FREQ_MHZ);
            15'd9:  rd_data = 64'(rd_hit_q);
            15'd10: rd_data = 64'(rd_miss_q);
            15'd11: rd_data = 64'(wr_hit_q);
            15'd12: rd_data = 64'(wr_miss_q);
            15'd13: rd_data = {62'h0, c1_alm_full, c0_alm_full};
            15'd14: rd_data = {63'h0, ovf_q};
            default: ;
        endcase
        for (int v = 0; v < NUM_VC; v++)
            if (s1_idx == 15'(16 + v)) rd_data = 64'(vc_q[v]);
        for (int i = 0; i < NUM_TEST_CSRS; i++) begin
            if (s1_idx == 15'(32 + i)) begin
                rd_data   = csr_rd_data[64*i +: 64];
                wr_dec[i] = s1_local && !s1_is_rd_q;
            end
        end
    end

    // AFU responses own the output; the local FIFO only drains in their gaps
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(RSP_FIFO_DEPTH));
    assign pop        = !afu_valid_q && !fifo_empty;
    assign push_ok    = s2_valid_q && (!fifo_full || pop);
    assign drop       = s2_valid_q && fifo_full && !pop;
    assign rsp_valid  = afu_valid_q || !fifo_empty;
    assign rsp_tid    = afu_valid_q ? afu_tid_q  : mem_q[rd_ptr_q][72:64];
    assign rsp_data   = afu_valid_q ? afu_data_q : mem_q[rd_ptr_q][63:0];
    assign csr_wr_en   = wr_en_q;
    assign csr_wr_data = wr_data_q;
    assign rsp_ovf     = ovf_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {s2_tid_q, s2_data_q};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;  s1_is_rd_q <= 1'b0;  s1_addr_q <= '0;
            s1_tid_q   <= '0;    s1_data_q  <= '0;
            s2_valid_q <= 1'b0;  s2_tid_q   <= '0;    s2_data_q <= '0;
            afu_valid_q <= 1'b0; afu_tid_q  <= '0;    afu_data_q <= '0;
            wr_en_q    <= '0;    wr_data_q  <= '0;
            freeze_q   <= 1'b0;  ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;    rd_ptr_q   <= '0;    count_q <= '0;
        end else begin
            s1_valid_q  <= mmio_req_valid;
            s1_is_rd_q  <= mmio_req_is_rd;
            s1_addr_q   <= mmio_req_addr;
            s1_tid_q    <= mmio_req_tid;
            s1_data_q   <= mmio_req_data;
            s2_valid_q  <= s1_local && s1_is_rd_q;
            s2_tid_q    <= s1_tid_q;
            s2_data_q   <= rd_data;
            afu_valid_q <= afu_rsp_valid;
            afu_tid_q   <= afu_rsp_tid;
            afu_data_q  <= afu_rsp_data;
            wr_en_q     <= wr_dec;
            wr_data_q   <= s1_data_q;
            if (ctrl_wr) freeze_q <= s1_data_q[0];
            if (clr)       ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
        end
    end

    assign wr_inc = 3'd1 + {1'b0, ev_wr_cl_q};

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            vc_inc[v] = 3'd0;
            if (ev_rd_valid_q && ev_rd_vc_q == 3'(v)) vc_inc[v] = 3'd1;
            if (ev_wr_valid_q && ev_wr_vc_q == 3'(v)) vc_inc[v] = vc_inc[v] + wr_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ev_rd_valid_q <= 1'b0; ev_rd_hit_q <= 1'b0; ev_rd_vc_q <= '0;
            ev_wr_valid_q <= 1'b0; ev_wr_hit_q <= 1'b0; ev_wr_vc_q <= '0;
            ev_wr_cl_q    <= '0;
        end else begin
            ev_rd_valid_q <= ev_rd_valid; ev_rd_hit_q <= ev_rd_hit; ev_rd_vc_q <= ev_rd_vc;
            ev_wr_valid_q <= ev_wr_valid; ev_wr_hit_q <= ev_wr_hit; ev_wr_vc_q <= ev_wr_vc;
            ev_wr_cl_q    <= ev_wr_cl_num;
        end
    end

    // Clear wins over any increment landing in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            rd_hit_q <= '0; rd_miss_q <= '0; wr_hit_q <= '0; wr_miss_q <= '0;
            for (int v = 0; v < NUM_VC; v++) vc_q[v] <= '0;
        end else if (!freeze_q) begin
            if (ev_rd_valid_q &&  ev_rd_hit_q) rd_hit_q  <= ctr_add(rd_hit_q, 3'd1);
            if (ev_rd_valid_q && !ev_rd_hit_q) rd_miss_q <= ctr_add(rd_miss_q, 3'd1);
            if (ev_wr_valid_q &&  ev_wr_hit_q) wr_hit_q  <= ctr_add(wr_hit_q, wr_inc);
            if (ev_wr_valid_q && !ev_wr_hit_q) wr_miss_q <= ctr_add(wr_miss_q, wr_inc);
            for (int v = 0; v < NUM_VC; v++) vc_q[v] <= ctr_add(vc_q[v], vc_inc[v]);
        end
    end
endmodule

// File: tb/tb_cci_test_csr_mgr.sv
// Self-checking bench for cci_test_csr_mgr with a small behavioural CSR/counter model.
module tb_cci_test_csr_mgr;
    localparam int NTC = 2, NVC = 3, CW = 4, DEPTH = 4;
    localparam logic [127:0] AID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam int NEXT = 256, FREQ = 400;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0, reset_n = 1'b0;
    logic mmio_req_valid = 0, mmio_req_is_rd = 0;
    logic [15:0] mmio_req_addr = '0;
    logic [8:0]  mmio_req_tid = '0;
    logic [63:0] mmio_req_data = '0;
    logic afu_rsp_valid = 0;
    logic [8:0]  afu_rsp_tid = '0;
    logic [63:0] afu_rsp_data = '0;
    logic rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic ev_rd_valid = 0, ev_rd_hit = 0, ev_wr_valid = 0, ev_wr_hit = 0;
    logic [2:0] ev_rd_vc = '0, ev_wr_vc = '0;
    logic [1:0] ev_wr_cl_num = '0;
    logic c0_alm_full = 0, c1_alm_full = 0;
    logic [NTC-1:0] csr_wr_en;
    logic [63:0] csr_wr_data;
    logic [64*NTC-1:0] csr_rd_data = '0;
    logic rsp_ovf;

    int checks = 0, errors = 0;
    int m_cnt [4];
    int m_vc [NVC];
    bit m_freeze, m_ovf;

    cci_test_csr_mgr #(.NUM_TEST_CSRS(NTC), .NUM_VC(NVC), .CTR_WIDTH(CW),
        .RSP_FIFO_DEPTH(DEPTH), .AFU_ID(AID), .NEXT_DFH_BYTE_OFFSET(NEXT),
        .CLOCK_FREQ_MHZ(FREQ)) dut (
        .clk(clk), .reset_n(reset_n),
        .mmio_req_valid(mmio_req_valid), .mmio_req_is_rd(mmio_req_is_rd),
        .mmio_req_addr(mmio_req_addr), .mmio_req_tid(mmio_req_tid),
        .mmio_req_data(mmio_req_data),
        .afu_rsp_valid(afu_rsp_valid), .afu_rsp_tid(afu_rsp_tid), .afu_rsp_data(afu_rsp_data),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
        .ev_rd_valid(ev_rd_valid), .ev_rd_vc(ev_rd_vc), .ev_rd_hit(ev_rd_hit),
        .ev_wr_valid(ev_wr_valid), .ev_wr_vc(ev_wr_vc), .ev_wr_hit(ev_wr_hit),
        .ev_wr_cl_num(ev_wr_cl_num), .c0_alm_full(c0_alm_full), .c1_alm_full(c1_alm_full),
        .csr_wr_en(csr_wr_en), .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data),
        .rsp_ovf(rsp_ovf));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic int cadd(input int a, input int b);
`ifdef CCI_TEST_CSR_SATURATE_EN
        return (a + b > CMAX) ? CMAX : a + b;
`else
        return (a + b) % (CMAX + 1);
`endif
    endfunction

    function automatic logic [63:0] exp_read(input int idx);
        if (idx == 0)  return {4'h1, 20'h0, 24'(NEXT), 16'h0};
        if (idx == 1)  return AID[63:0];
        if (idx == 2)  return AID[127:64];
        if (idx == 5)  return {62'h0, m_freeze, 1'b0};
        if (idx == 8)  return 64'(FREQ);
        if (idx >= 9 && idx <= 12) return 64'(m_cnt[idx-9]);
        if (idx == 13) return {62'h0, c1_alm_full, c0_alm_full};
        if (idx == 14) return {63'h0, m_ovf};
        if (idx >= 16 && idx < 16 + NVC) return 64'(m_vc[idx-16]);
        if (idx >= 32 && idx < 32 + NTC) return csr_rd_data[64*(idx-32) +: 64];
        return 64'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        for (int v = 0; v < NVC; v++) m_vc[v] = 0;
        m_ovf = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0; mmio_req_valid = 0; afu_rsp_valid = 0;
        ev_rd_valid = 0; ev_wr_valid = 0;
        step(); step();
        reset_n = 1;
        model_clear();
        m_freeze = 0;
    endtask

    task automatic send(input bit rd, input int idx, input bit odd,
                        input logic [8:0] tid, input logic [63:0] d);
        mmio_req_valid = 1; mmio_req_is_rd = rd;
        mmio_req_addr = 16'(idx * 2 + int'(odd));
        mmio_req_tid = tid; mmio_req_data = d;
        step();
        mmio_req_valid = 0;
    endtask

    task automatic read_csr(input int idx, output logic [63:0] d);
        logic [8:0] tid;
        bit got;
        tid = 9'($urandom);
        got = 0;
        d = 'x;
        send(1, idx, 0, tid, 64'h0);
        for (int i = 0; i < 10 && !got; i++) begin
            if (rsp_valid && rsp_tid == tid) begin
                got = 1;
                d = rsp_data;
            end else step();
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL read_timeout idx %0d no response", idx);
        end
    endtask

    task automatic write_ctrl(input logic [63:0] d);
        send(0, 5, 0, 9'h0, d);
        step();
        if (d[1]) begin model_clear(); end
        m_freeze = d[0];
    endtask

    task automatic ev_cycle(input bit rv, input int rvc, input bit rh,
                            input bit wv, input int wvc, input bit wh, input int cl);
        ev_rd_valid = rv; ev_rd_vc = 3'(rvc); ev_rd_hit = rh;
        ev_wr_valid = wv; ev_wr_vc = 3'(wvc); ev_wr_hit = wh; ev_wr_cl_num = 2'(cl);
        if (!m_freeze) begin
            if (rv) begin
                m_cnt[rh ? 0 : 1] = cadd(m_cnt[rh ? 0 : 1], 1);
                if (rvc < NVC) m_vc[rvc] = cadd(m_vc[rvc], 1);
            end
            if (wv) begin
                m_cnt[wh ? 2 : 3] = cadd(m_cnt[wh ? 2 : 3], 1 + cl);
                if (wvc < NVC) m_vc[wvc] = cadd(m_vc[wvc], 1 + cl);
            end
        end
        step();
        ev_rd_valid = 0; ev_wr_valid = 0;
    endtask

    task automatic check_counters(input string tag);
        logic [63:0] d;
        int idxs [8] = '{5, 9, 10, 11, 12, 16, 17, 18};
        for (int k = 0; k < 8; k++) begin
            read_csr(idxs[k], d);
            checks++;
            if (d !== exp_read(idxs[k])) begin
                errors++;
                $display("FAIL %s idx %0d got %0h exp %0h", tag, idxs[k], d, exp_read(idxs[k]));
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        step();
        checks++;
        if ({rsp_valid, csr_wr_en, rsp_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {rsp_valid, csr_wr_en, rsp_ovf});
        end
        do_reset();
        check_counters("reset_regs");
    endtask

    task automatic test_dfh_id();
        int idx [3] = '{0, 1, 2};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c >= 3 && c <= 5) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_tid !== 9'(8'h11 + c - 3) ||
                    rsp_data !== exp_read(idx[c-3])) begin
                    errors++;
                    $display("FAIL dfh_id rsp %0d got v%b tid %0h data %0h exp tid %0h data %0h",
                             c - 3, rsp_valid, rsp_tid, rsp_data, 8'h11 + c - 3, exp_read(idx[c-3]));
                end
            end else begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL dfh_id idle cycle %0d got rsp_valid %b exp 0", c, rsp_valid);
                end
            end
            mmio_req_valid = (c < 3);
            mmio_req_is_rd = 1;
            mmio_req_addr = 16'(c * 2);
            mmio_req_tid = 9'(8'h11 + c);
            step();
        end
        mmio_req_valid = 0;
    endtask

    task automatic test_random_reads();
        int pool [16] = '{0, 1, 2, 3, 4, 5, 6, 8, 13, 14, 16, 17, 18, 19, 32, 33};
        bit e_v [32];
        logic [8:0] e_tid [32];
        logic [63:0] e_data [32];
        int r, idx;
        bit odd;
        do_reset();
        c0_alm_full = 1'($urandom); c1_alm_full = 1'($urandom);
        csr_rd_data = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 32; k++) e_v[k] = 0;
        for (int c = 0; c < 28; c++) begin
            checks++;
            if (rsp_valid !== e_v[c] ||
                (e_v[c] && (rsp_tid !== e_tid[c] || rsp_data !== e_data[c]))) begin
                errors++;
                $display("FAIL rand_read cycle %0d got v%b tid %0h data %0h exp v%b tid %0h data %0h",
                         c, rsp_valid, rsp_tid, rsp_data, e_v[c], e_tid[c], e_data[c]);
            end
            mmio_req_valid = 0;
            if (c < 24) begin
                r = $urandom_range(0, 19);
                idx = (r < 16) ? pool[r] : (r == 16) ? 34 : (r == 17) ? 35 : (r == 18) ? 31 : 15;
                odd = ($urandom_range(0, 5) == 0);
                mmio_req_valid = 1; mmio_req_is_rd = 1;
                mmio_req_addr = 16'(idx * 2 + int'(odd));
                mmio_req_tid = 9'($urandom);
                e_v[c+3] = !odd && idx < 32 + NTC;
                e_tid[c+3] = mmio_req_tid;
                e_data[c+3] = exp_read(idx);
            end
            step();
        end
        mmio_req_valid = 0;
    endtask

    task automatic test_writes();
        logic [63:0] d;
        do_reset();
        for (int i = 0; i < NTC; i++) begin
            d = (i == 1) ? 64'hDEAD_BEEF : {$urandom, $urandom};
            send(0, 32 + i, 0, 9'h5, d);
            checks++;
            if (csr_wr_en !== '0) begin
                errors++; $display("FAIL wr_early csr %0d got %b exp 0", i, csr_wr_en);
            end
            step();
            checks++;
            if (csr_wr_en !== NTC'(1 << i) || csr_wr_data !== d) begin
                errors++;
                $display("FAIL wr_strobe csr %0d got en %b data %0h exp en %b data %0h",
                         i, csr_wr_en, csr_wr_data, NTC'(1 << i), d);
            end
            step();
            checks++;
            if (csr_wr_en !== '0) begin
                errors++; $display("FAIL wr_pulse_len csr %0d got %b exp 0", i, csr_wr_en);
            end
        end
        for (int t = 0; t < 2; t++) begin
            send(0, (t == 0) ? 32 + NTC : 33, t == 1, 9'h6, 64'h1234);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (csr_wr_en !== '0) begin
                    errors++; $display("FAIL wr_ignored case %0d got %b exp 0", t, csr_wr_en);
                end
                step();
            end
        end
    endtask

    task automatic test_overflow();
        int idx [5] = '{8, 1, 2, 13, 0};
        logic [63:0] a_data [10];
        logic [63:0] d;
        do_reset();
        for (int i = 0; i < 10; i++) a_data[i] = {$urandom, $urandom};
        for (int c = 0; c < 16; c++) begin
            if (c >= 1 && c <= 10) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_tid !== 9'(9'h100 + c - 1) || rsp_data !== a_data[c-1]) begin
                    errors++;
                    $display("FAIL afu_pass cycle %0d got v%b tid %0h data %0h exp tid %0h data %0h",
                             c, rsp_valid, rsp_tid, rsp_data, 9'h100 + c - 1, a_data[c-1]);
                end
            end else if (c >= 11 && c <= 14) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_tid !== 9'(9'h20 + c - 11) ||
                    rsp_data !== exp_read(idx[c-11])) begin
                    errors++;
                    $display("FAIL local_after_afu %0d got v%b tid %0h data %0h exp tid %0h data %0h",
                             c - 11, rsp_valid, rsp_tid, rsp_data, 9'h20 + c - 11, exp_read(idx[c-11]));
                end
            end else if (c == 15) begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++; $display("FAIL dropped_5th got rsp_valid %b exp 0", rsp_valid);
                end
            end
            afu_rsp_valid = (c < 10);
            afu_rsp_tid = 9'(9'h100 + c);
            afu_rsp_data = (c < 10) ? a_data[c] : 64'h0;
            mmio_req_valid = (c >= 1 && c <= 5);
            mmio_req_is_rd = 1;
            mmio_req_addr = (c >= 1 && c <= 5) ? 16'(idx[c-1] * 2) : 16'h0;
            mmio_req_tid = 9'(9'h20 + c - 1);
            step();
        end
        afu_rsp_valid = 0; mmio_req_valid = 0;
        m_ovf = 1;
        checks++;
        if (rsp_ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got %b exp 1", rsp_ovf);
        end
        read_csr(14, d);
        checks++;
        if (d !== exp_read(14)) begin
            errors++; $display("FAIL ovf_read got %0h exp %0h", d, exp_read(14));
        end
        write_ctrl(64'h2);
        checks++;
        if (rsp_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clear got %b exp 0", rsp_ovf);
        end
        read_csr(14, d);
        checks++;
        if (d !== exp_read(14)) begin
            errors++; $display("FAIL ovf_read_clr got %0h exp %0h", d, exp_read(14));
        end
    endtask

    task automatic test_counters();
        do_reset();
        for (int j = 0; j < 3; j++) ev_cycle(0, 0, 0, 1, 1, 1, 3);
        for (int j = 0; j < 2; j++) ev_cycle(1, 1, 0, 0, 0, 0, 0);
        step(); step(); step();
        check_counters("ctr_script");
        write_ctrl(64'h1);
        step(); step();
        for (int j = 0; j < 3; j++) ev_cycle(0, 0, 0, 1, 1, 1, 3);
        for (int j = 0; j < 2; j++) ev_cycle(1, 1, 0, 0, 0, 0, 0);
        step(); step(); step();
        check_counters("ctr_frozen");
        // Clear request and a read event in the same cycle, then one more event
        mmio_req_valid = 1; mmio_req_is_rd = 0; mmio_req_addr = 16'(5 * 2);
        mmio_req_data = 64'h2;
        ev_rd_valid = 1; ev_rd_vc = 3'd0; ev_rd_hit = 1;
        step();
        mmio_req_valid = 0; ev_rd_valid = 0;
        model_clear(); m_freeze = 0;
        ev_cycle(1, 0, 1, 0, 0, 0, 0);
        step(); step(); step();
        check_counters("ctr_clear");
    endtask

    task automatic test_random_counters();
        do_reset();
        for (int j = 0; j < 40; j++)
            ev_cycle(1'($urandom), $urandom_range(0, 7), 1'($urandom),
                     1'($urandom), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 3));
        step(); step(); step();
        check_counters("ctr_random");
    endtask

    task automatic test_saturate();
        logic [63:0] d;
        do_reset();
        for (int j = 0; j < 20; j++) ev_cycle(1, 0, 1, 0, 0, 0, 0);
        step(); step(); step();
        read_csr(9, d);
        checks++;
`ifdef CCI_TEST_CSR_SATURATE_EN
        if (d !== 64'd15) begin
            errors++; $display("FAIL ctr_limit got %0d exp 15", d);
        end
`else
        if (d !== 64'd4) begin
            errors++; $display("FAIL ctr_limit got %0d exp 4", d);
        end
`endif
        check_counters("ctr_limit_model");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int j = 0; j < 3; j++) ev_cycle(1, 2, 1, 1, 0, 0, 2);
        write_ctrl(64'h1);
        afu_rsp_valid = 1; afu_rsp_tid = 9'h1FF; afu_rsp_data = 64'h0;
        for (int c = 0; c < 6; c++) begin
            mmio_req_valid = (c < 2); mmio_req_is_rd = 1;
            mmio_req_addr = 16'(8 * 2); mmio_req_tid = 9'(c);
            step();
        end
        reset_n = 0; afu_rsp_valid = 0; mmio_req_valid = 0;
        step();
        checks++;
        if ({rsp_valid, csr_wr_en, rsp_ovf} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b exp 0", {rsp_valid, csr_wr_en, rsp_ovf});
        end
        reset_n = 1;
        model_clear(); m_freeze = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL stale_rsp cycle %0d got %b exp 0", c, rsp_valid);
            end
        end
        check_counters("after_mid_reset");
    endtask

    initial begin
        model_clear();
        m_freeze = 0;
        test_reset();
        test_dfh_id();
        test_random_reads();
        test_writes();
        test_overflow();
        test_counters();
        test_random_counters();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cci_test_csr_mgr.md
# cci_test_csr_mgr

Parametrised, generic MMIO CSR manager for CCI test AFUs, sitting between the FIU MMIO path and test logic. It decodes MMIO reads and writes to a local CSR window: DFH, AFU ID, a control register, status, cache hit/miss counters, per-VC counters and NUM_TEST_CSRS test registers. Local read responses are queued in a response FIFO and merged with AFU-generated MMIO responses, so a local read is never lost to a simultaneous AFU response. Counters gain freeze and clear control.

## Interface
- NUM_TEST_CSRS, 16, number of test CSRs (1..64), at index 32 upward
- NUM_VC, 3, per-VC counter count (1..8)
- CTR_WIDTH, 48, event counter width (≤64)
- RSP_FIFO_DEPTH, 4, local read-response FIFO depth (power of 2, ≥2)
- AFU_ID, 128'h0, AFU UUID
- NEXT_DFH_BYTE_OFFSET, 0, DFH nextFeature field
- CLOCK_FREQ_MHZ, 400, value returned at index 8
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- mmio_req_valid  in  1  MMIO request this cycle
- mmio_req_is_rd  in  1  1 = read, 0 = write
- mmio_req_addr  in  16  4-byte word address; CSR index = addr[15:1]
- mmio_req_tid  in  9  request TID
- mmio_req_data  in  64  write data
- afu_rsp_valid / afu_rsp_tid / afu_rsp_data  in  1/9/64  AFU-generated MMIO read response
- rsp_valid / rsp_tid / rsp_data  out  1/9/64  merged response to FIU
- ev_rd_valid, ev_rd_vc[2:0], ev_rd_hit  in  read-response event
- ev_wr_valid, ev_wr_vc[2:0], ev_wr_hit, ev_wr_cl_num[1:0]  in  write-response event
- c0_alm_full, c1_alm_full  in  1  FIU almost-full flags
- csr_wr_en  out  NUM_TEST_CSRS  one-hot test CSR write strobe
- csr_wr_data  out  64  test CSR write data
- csr_rd_data  in  64·NUM_TEST_CSRS  test CSR read values; CSR i at [64i +: 64]
- rsp_ovf  out  1  sticky local-response overflow

## Operation
- Request is local when addr[0]=0 and index < 32+NUM_TEST_CSRS. Otherwise it is ignored: no response, no write.
- Read map:
  - 0: DFH, type AFU, nextFeature = NEXT_DFH_BYTE_OFFSET
  - 1/2: AFU_ID[63:0] / AFU_ID[127:64]
  - 3, 4: 0
  - 5: control {62'0, freeze, 0}
  - 8: CLOCK_FREQ_MHZ
  - 9–12: rd hits, rd misses, wr hits, wr misses
  - 13: {62'0, c1_alm_full, c0_alm_full}
  - 14: {63'0, rsp_ovf}
  - 16+v: VC v count, for v < NUM_VC
  - 32+i: csr_rd_data CSR i
  - Other local indices: 0
  - Counters are zero-extended to 64 bits.
- Writes:
  - Index 32+i pulses csr_wr_en[i] for one cycle; csr_wr_data = request data.
  - Index 5: bit0 sets freeze (level); bit1 = clear pulse, which zeroes all counters and rsp_ovf.
  - Other writes are ignored.
- Counters:
  - Read events add 1 to hit or miss.
  - Write events add 1+cl_num to hit or miss.
  - VC v counts read (1) plus write (1+cl_num) events with vc==v; both events in the same cycle add together. vc ≥ NUM_VC is ignored.
  - While freeze=1, counters hold.
  - Clear has priority over same-cycle increments.
- Merge: AFU responses have priority. The FIFO head drains only in cycles with no registered AFU response.
- FIFO full at enqueue time: drop the local read and set rsp_ovf. Simultaneous enqueue and dequeue when full is not a drop.

## Timing
- Stage 1 registers the request. Stage 2 decodes and pushes to the FIFO. rsp_valid is asserted no earlier than the cycle after the push, so minimum local read latency is 3 cycles.
- AFU response path: 1 registered cycle, unconditionally passed through.
- csr_wr_en asserts 2 cycles after the write request.
- Control write takes effect 2 cycles after the request.
- Event counters: counter visible 2 cycles after the event (input register, then accumulate).
- Reset (reset_n=0 at a clk edge), same cycle, including mid-operation:
  - Outputs: rsp_valid=0, csr_wr_en=0, rsp_ovf=0.
  - State: FIFO empty, in-flight requests discarded, freeze=0, all counters 0.
  - rsp_tid, rsp_data and csr_wr_data are don't-care while their valids are low.

## Configuration
- CCI_TEST_CSR_SATURATE_EN defined: each counter saturates at 2^CTR_WIDTH−1. An addition that would exceed the maximum yields the maximum.
- Undefined: counters wrap modulo 2^CTR_WIDTH.

## Test plan
- Read index 0, 1, 2 with TIDs 0x11, 0x12, 0x13, no AFU traffic → rsp at +3 cycles: DFH with type AFU, then AFU_ID low, then AFU_ID high, TIDs preserved in order.
- Write 0xDEAD_BEEF to index 33 → csr_wr_en = 2'b10 pulse for exactly 1 cycle at +2, csr_wr_data = 0xDEADBEEF. Write to index 32+NUM_TEST_CSRS → no strobe. Odd address → no strobe.
- 5 local reads back-to-back while afu_rsp_valid is held high 10 cycles, DEPTH=4 → 4 local responses emerge after the AFU burst, 5th dropped, index 14 reads 1. Write control bit1 → index 14 reads 0.
- 3 write events (vc=1, hit, cl_num=3) plus 2 read events (vc=1, miss) → wr hits = 12, rd misses = 2, VC1 = 14. Same stimulus with freeze=1 → all unchanged.
- Clear pulse in the same cycle as a read event → counter reads 0.
- CTR_WIDTH=4, 20 read hits → 15 with the macro defined, 4 without.
- Assert reset_n=0 with 2 responses queued → no rsp_valid after reset. All counters and control read 0 after reset.
